// File: rtl/rxc_pkg.sv
// Shared definitions for the spiNNlink receiver control: K-character codes,
// rx_state encodings, word classes and the word classifier.
package rxc_pkg;

  localparam logic [7:0] COMMA     = 8'hBC;
  localparam logic [7:0] SYNC      = 8'h3C;
  localparam logic [7:0] CLKC      = 8'h1C;
  localparam logic [3:0] KCHR_SYNC = 4'b1010;
  localparam logic [3:0] KCHR_CLKC = 4'b0001;
  localparam logic [7:0] RS_MAX    = 8'h03;

  typedef enum logic [1:0] {
    ST_SEARCH     = 2'b00,
    ST_LOCAL_SYNC = 2'b01,
    ST_HANDSHAKE  = 2'b10,
    ST_LINK_UP    = 2'b11
  } rx_state_t;

  typedef enum logic [1:0] {
    WC_DATA = 2'b00,
    WC_SYNC = 2'b01,
    WC_CLKC = 2'b10,
    WC_ERR  = 2'b11
  } word_class_t;

  // Error overrides everything; byte0 of a sync word carries a sequence number and is ignored.
  function automatic word_class_t classify(input logic [31:0] data,
                                           input logic [3:0]  kchr,
                                           input logic        err);
    word_class_t cls;
    cls = WC_DATA;
    if (err) begin
      cls = WC_ERR;
    end else if ((kchr == KCHR_SYNC) && (data[31:24] == COMMA) &&
                 (data[15:8] == SYNC) && (data[23:16] <= RS_MAX)) begin
      cls = WC_SYNC;
    end else if ((kchr == KCHR_CLKC) && (data == {4{CLKC}})) begin
      cls = WC_CLKC;
    end else begin
      cls = WC_DATA;
    end
    return cls;
  endfunction

endpackage

// File: rtl/rxc_sat_cnt.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module rxc_sat_cnt
  import rxc_pkg::*;
#(
  parameter int MAX = 16,
  parameter int W   = $clog2(MAX + 1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt,
  output logic         at_max
);

  localparam logic [W-1:0] MAX_V = W'(MAX);
  localparam logic [W-1:0] ONE_V = W'(1);

  assign at_max = (cnt == MAX_V);

  // count register
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (inc && !at_max) begin
      cnt <= cnt + ONE_V;
    end
  end

endmodule

// File: rtl/rxc.sv
// spiNNlink receiver control: classifies GTP words, runs the link handshake
// and forwards data words to the framer once the link is up.
module rxc
  import rxc_pkg::*;
#(
  parameter int SYNC_GOOD_CNT = 16,
  parameter int SYNC_TO_CNT   = 1024,
  parameter int ERR_LIMIT     = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] gtp_data,
  input  logic [3:0]  gtp_kchr,
  input  logic        gtp_rx_err,
  output logic [1:0]  rx_state,
  output logic [31:0] rx_out_data,
  output logic [3:0]  rx_out_kchr,
  output logic        rx_out_vld
);

  localparam int GOOD_W = $clog2(SYNC_GOOD_CNT + 1);
  localparam int TO_W   = $clog2(SYNC_TO_CNT + 1);
  localparam int ERR_W  = $clog2(ERR_LIMIT + 1);

  // "reaches the limit including the current word" means the count is one short before it
  localparam logic [GOOD_W-1:0] GOOD_M1 = GOOD_W'(SYNC_GOOD_CNT - 1);
  localparam logic [TO_W-1:0]   TO_M1   = TO_W'(SYNC_TO_CNT - 1);
  localparam logic [ERR_W-1:0]  ERR_M1  = ERR_W'(ERR_LIMIT - 1);

  rx_state_t         state;
  rx_state_t         state_nxt;
  word_class_t       cls;
  logic              is_sync;
  logic              is_clkc;
  logic              is_err;
  logic              is_data;
  logic [1:0]        rs;
  logic              state_chg;
  logic              fwd;
  logic              good_hit;
  logic              to_hit;
  logic              err_hit;
  logic [GOOD_W-1:0] good_cnt;
  logic [TO_W-1:0]   to_cnt;
  logic [ERR_W-1:0]  err_cnt;
  logic              good_max;
  logic              to_max;
  logic              err_max;

  assign cls     = classify(gtp_data, gtp_kchr, gtp_rx_err);
  assign is_sync = (cls == WC_SYNC);
  assign is_clkc = (cls == WC_CLKC);
  assign is_err  = (cls == WC_ERR);
  assign is_data = (cls == WC_DATA);
  assign rs      = gtp_data[17:16];

  assign good_hit = (is_sync && (good_cnt >= GOOD_M1)) || (is_clkc && good_max);
  assign to_hit   = (!is_sync && (to_cnt >= TO_M1)) || (!is_sync && to_max);
  assign err_hit  = (is_err && (err_cnt >= ERR_M1)) || (is_err && err_max);

  rxc_sat_cnt #(.MAX(SYNC_GOOD_CNT), .W(GOOD_W)) u_good_cnt (
    .clk    (clk),
    .rst    (rst),
    .inc    (is_sync),
    .clr    (is_err || is_data || state_chg),
    .cnt    (good_cnt),
    .at_max (good_max)
  );

  rxc_sat_cnt #(.MAX(SYNC_TO_CNT), .W(TO_W)) u_to_cnt (
    .clk    (clk),
    .rst    (rst),
    .inc    (!is_sync),
    .clr    (is_sync || state_chg),
    .cnt    (to_cnt),
    .at_max (to_max)
  );

  rxc_sat_cnt #(.MAX(ERR_LIMIT), .W(ERR_W)) u_err_cnt (
    .clk    (clk),
    .rst    (rst),
    .inc    (is_err),
    .clr    (!is_err || state_chg),
    .cnt    (err_cnt),
    .at_max (err_max)
  );

  // handshake next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ST_SEARCH: begin
        if (good_hit) begin
          state_nxt = ST_LOCAL_SYNC;
        end else begin
          state_nxt = ST_SEARCH;
        end
      end
      ST_LOCAL_SYNC: begin
        if (is_sync && (rs >= 2'b01)) begin
          state_nxt = ST_HANDSHAKE;
        end else if (to_hit) begin
          state_nxt = ST_SEARCH;
        end else begin
          state_nxt = ST_LOCAL_SYNC;
        end
      end
      ST_HANDSHAKE: begin
        // a data word means the partner already reached LINK_UP
        if (is_sync && (rs >= 2'b10)) begin
          state_nxt = ST_LINK_UP;
        end else if (is_data) begin
          state_nxt = ST_LINK_UP;
        end else if (is_sync && (rs == 2'b00)) begin
          state_nxt = ST_LOCAL_SYNC;
        end else if (to_hit) begin
          state_nxt = ST_SEARCH;
        end else begin
          state_nxt = ST_HANDSHAKE;
        end
      end
      ST_LINK_UP: begin
        if (is_sync && (rs <= 2'b01)) begin
          state_nxt = ST_SEARCH;
        end else if (err_hit) begin
          state_nxt = ST_SEARCH;
        end else begin
          state_nxt = ST_LINK_UP;
        end
      end
      default: state_nxt = ST_SEARCH;
    endcase
  end

  assign state_chg = (state_nxt != state);
  assign fwd       = is_data && (state_nxt == ST_LINK_UP) &&
                     ((state == ST_LINK_UP) || (state == ST_HANDSHAKE));

  // state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_SEARCH;
    end else begin
      state <= state_nxt;
    end
  end

  // forwarded word; data and K flags hold between valid words
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_out_vld  <= 1'b0;
      rx_out_data <= 32'h0000_0000;
      rx_out_kchr <= 4'b0000;
    end else begin
      rx_out_vld <= fwd;
      if (fwd) begin
        rx_out_data <= gtp_data;
        rx_out_kchr <= gtp_kchr;
      end
    end
  end

  assign rx_state = state;

endmodule

// File: tb/tb_rxc.sv
// Directed, table-driven bench for rxc with hand-written timeout and reset sequences.
module tb_rxc;

  localparam logic [7:0] K_COMMA = 8'hBC;
  localparam logic [7:0] K_SYNC  = 8'h3C;
  localparam logic [7:0] K_CLKC  = 8'h1C;

  typedef struct {
    logic [31:0] data;
    logic [3:0]  kchr;
    logic        err;
    logic [1:0]  st;
    logic        vld;
    logic [31:0] od;
    logic [3:0]  ok;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] gtp_data;
  logic [3:0]  gtp_kchr;
  logic        gtp_rx_err;
  logic [1:0]  rx_state;
  logic [31:0] rx_out_data;
  logic [3:0]  rx_out_kchr;
  logic        rx_out_vld;

  int          n_vec  = 0;
  int          n_miss = 0;
  vec_t        vq[$];
  logic [31:0] hd;
  logic [3:0]  hk;

  rxc dut (
    .clk         (clk),
    .rst         (rst),
    .gtp_data    (gtp_data),
    .gtp_kchr    (gtp_kchr),
    .gtp_rx_err  (gtp_rx_err),
    .rx_state    (rx_state),
    .rx_out_data (rx_out_data),
    .rx_out_kchr (rx_out_kchr),
    .rx_out_vld  (rx_out_vld)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] sync_w(input logic [1:0] rs);
    return {K_COMMA, 6'b000000, rs, K_SYNC, 8'h5A};
  endfunction

  function automatic logic [31:0] clkc_w();
    return {K_CLKC, K_CLKC, K_CLKC, K_CLKC};
  endfunction

  // expected held output tracks the last forwarded word
  function automatic void add(input logic [31:0] d, input logic [3:0] k, input logic e,
                              input logic [1:0] st, input logic v);
    if (v) begin
      hd = d;
      hk = k;
    end
    vq.push_back('{data: d, kchr: k, err: e, st: st, vld: v, od: hd, ok: hk});
  endfunction

  task automatic check(input string name, input logic [1:0] st, input logic v,
                       input logic [31:0] od, input logic [3:0] ok);
    n_vec++;
    if (rx_state !== st || rx_out_vld !== v || rx_out_data !== od || rx_out_kchr !== ok) begin
      n_miss++;
      $display("FAIL %s: got state=%b vld=%b data=%h kchr=%h, want state=%b vld=%b data=%h kchr=%h",
               name, rx_state, rx_out_vld, rx_out_data, rx_out_kchr, st, v, od, ok);
    end
  endtask

  task automatic drive(input logic [31:0] d, input logic [3:0] k, input logic e);
    gtp_data   = d;
    gtp_kchr   = k;
    gtp_rx_err = e;
    @(posedge clk);
    #1;
  endtask

  initial begin
    hd = 32'h0;
    hk = 4'h0;

    // 1: 16 syncs rs=00 with CLKC in between -> 01 right after the 16th
    for (int i = 0; i < 16; i++) begin
      add(sync_w(2'b00), 4'b1010, 1'b0, (i == 15) ? 2'b01 : 2'b00, 1'b0);
      if (i < 15) add(clkc_w(), 4'b0001, 1'b0, 2'b00, 1'b0);
    end
    // 2: bring-up and first data word
    add(sync_w(2'b01), 4'b1010, 1'b0, 2'b10, 1'b0);
    add(sync_w(2'b10), 4'b1010, 1'b0, 2'b11, 1'b0);
    add(32'h1234_5678, 4'b0000, 1'b0, 2'b11, 1'b1);
    add(32'hA5A5_0001, 4'b0100, 1'b0, 2'b11, 1'b1);
    add(clkc_w(), 4'b0001, 1'b0, 2'b11, 1'b0);
    // 4: 7 errors then data keep the link; 8 errors drop it
    for (int i = 0; i < 7; i++) add(32'hDEAD_0000, 4'b0000, 1'b1, 2'b11, 1'b0);
    add(32'h0BAD_BEEF, 4'b0000, 1'b0, 2'b11, 1'b1);
    for (int i = 0; i < 8; i++) add(sync_w(2'b10), 4'b1010, 1'b1, (i == 7) ? 2'b00 : 2'b11, 1'b0);
    // malformed sync (byte2 = 04) is DATA and restarts the good count
    for (int i = 0; i < 15; i++) add(sync_w(2'b00), 4'b1010, 1'b0, 2'b00, 1'b0);
    add({K_COMMA, 8'h04, K_SYNC, 8'h00}, 4'b1010, 1'b0, 2'b00, 1'b0);
    for (int i = 0; i < 16; i++) add(sync_w(2'b00), 4'b1010, 1'b0, (i == 15) ? 2'b01 : 2'b00, 1'b0);
    // 10 falls back to 01 on rs=00; 3: early partner data in 10
    add(sync_w(2'b01), 4'b1010, 1'b0, 2'b10, 1'b0);
    add(sync_w(2'b00), 4'b1010, 1'b0, 2'b01, 1'b0);
    add(sync_w(2'b01), 4'b1010, 1'b0, 2'b10, 1'b0);
    add(32'hCAFE_F00D, 4'b0000, 1'b0, 2'b11, 1'b1);
    // 5: rs=11 keeps the link, rs=00 drops it
    add(sync_w(2'b11), 4'b1010, 1'b0, 2'b11, 1'b0);
    add(sync_w(2'b00), 4'b1010, 1'b0, 2'b00, 1'b0);

    rst        = 1'b1;
    gtp_data   = 32'h0;
    gtp_kchr   = 4'h0;
    gtp_rx_err = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset", 2'b00, 1'b0, 32'h0, 4'h0);
    rst = 1'b0;

    foreach (vq[i]) begin
      drive(vq[i].data, vq[i].kchr, vq[i].err);
      check($sformatf("vec%0d", i), vq[i].st, vq[i].vld, vq[i].od, vq[i].ok);
    end

    // timeout in 01: 1024 DATA/CLKC words without a sync
    for (int i = 0; i < 16; i++) drive(sync_w(2'b00), 4'b1010, 1'b0);
    check("to_enter01", 2'b01, 1'b0, hd, hk);
    for (int i = 0; i < 1024; i++) begin
      if (i % 2 == 0) drive(32'h0000_0100 + i, 4'b0000, 1'b0);
      else            drive(clkc_w(), 4'b0001, 1'b0);
      if (i >= 1020) check($sformatf("timeout%0d", i), (i == 1023) ? 2'b00 : 2'b01, 1'b0, hd, hk);
    end

    // reset while in LINK_UP
    for (int i = 0; i < 16; i++) drive(sync_w(2'b00), 4'b1010, 1'b0);
    drive(sync_w(2'b01), 4'b1010, 1'b0);
    drive(sync_w(2'b10), 4'b1010, 1'b0);
    drive(32'h1111_2222, 4'b0010, 1'b0);
    check("pre_rst_up", 2'b11, 1'b1, 32'h1111_2222, 4'b0010);
    rst = 1'b1;
    drive(32'h3333_4444, 4'b0000, 1'b0);
    check("mid_rst", 2'b00, 1'b0, 32'h0, 4'h0);
    rst = 1'b0;
    drive(32'h5555_6666, 4'b0000, 1'b0);
    check("post_rst_data", 2'b00, 1'b0, 32'h0, 4'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
